// File: rtl/dsp_sys_arr_pkg.sv
// Shared types for the systolic array datapath and its operand feeder.
// No logic: types, widths and the feeder state encoding only.
package dsp_sys_arr_pkg;

    localparam int SNGL_FLT_SIZE = 32;

    typedef logic [SNGL_FLT_SIZE-1:0] single_float;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        FEED,
        DONE
    } feeder_state_t;

endpackage

// File: rtl/operand_lane.sv
// One feeder lane: streams N buffered operands over valid/ready, data muxed combinationally from idx.
// Zero-latency data; holds the current element while ready is low, then drops valid after the N-th handshake.
module operand_lane
    import dsp_sys_arr_pkg::*;
#(
    parameter int N = 3
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        clr,
    input  logic        en_in,
    input  single_float buf_in [N],
    input  logic        ready,
    output logic        valid,
    output single_float dat,
    output logic        started,
    output logic        finished,
    output logic        last_hs
);

    localparam int IW = $clog2(N + 1);

    logic [IW-1:0] idx_q, idx_d;
    logic          en_q, en_d;
    logic [IW-1:0] sel;

    assign finished = (idx_q == IW'(N));
    assign started  = (idx_q != '0);
    // en_in counts immediately so the head lane is valid in the first FEED cycle
    assign valid    = !finished && (en_q || en_in);
    assign last_hs  = valid && ready && (idx_q == IW'(N - 1));
    assign sel      = finished ? IW'(N - 1) : idx_q;

    always_comb begin
        dat = '0;
        for (int n = 0; n < N; n++) begin
            if (sel == IW'(n)) begin
                dat = buf_in[n];
            end
        end
    end

    always_comb begin
        idx_d = idx_q;
        en_d  = en_q;
        if (clr) begin
            idx_d = '0;
            en_d  = 1'b0;
        end else begin
            if (en_in) begin
                en_d = 1'b1;
            end
            if (valid && ready) begin
                idx_d = idx_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            idx_q <= '0;
            en_q  <= 1'b0;
        end else begin
            idx_q <= idx_d;
            en_q  <= en_d;
        end
    end

endmodule

// File: rtl/sys_arr_operand_feeder.sv
// Buffers A (row-major) then B (column-major) from a serial load stream, then skew-feeds M row and K column lanes.
// Load accepts one element per cycle in LOAD; each lane stalls independently on its own ready.
module sys_arr_operand_feeder
    import dsp_sys_arr_pkg::*;
#(
    parameter int M = 2,
    parameter int N = 3,
    parameter int K = 2
) (
    input  logic                       clk,
    input  logic                       nrst,
    input  logic                       start,
    input  logic                       ld_valid,
    output logic                       ld_ready,
    input  single_float                ld_dat,
    output logic [M*SNGL_FLT_SIZE-1:0] row_dat,
    output logic [M-1:0]               row_valid,
    input  logic [M-1:0]               row_ready,
    output logic [K*SNGL_FLT_SIZE-1:0] col_dat,
    output logic [K-1:0]               col_valid,
    input  logic [K-1:0]               col_ready,
    output logic                       busy,
    output logic                       feed_done
);

    localparam int NL  = M + K;
    localparam int TOT = M * N + N * K;
    localparam int LW  = $clog2(TOT + 1);

    feeder_state_t state_q;
    logic [LW-1:0] ld_cnt_q;
    single_float   buf_q [TOT];
    logic          ld_ready_q, busy_q, feed_done_q;

    logic          clr, feeding, ld_hs, all_done;
    logic          lane_en    [NL];
    logic          lane_rdy   [NL];
    logic          lane_vld   [NL];
    single_float   lane_dat   [NL];
    logic          lane_start [NL];
    logic          lane_fin   [NL];
    logic          lane_last  [NL];

    assign clr       = start && (state_q == IDLE || state_q == DONE);
    assign feeding   = (state_q == FEED);
    assign ld_hs     = ld_valid && ld_ready_q;
    assign ld_ready  = ld_ready_q;
    assign busy      = busy_q;
    assign feed_done = feed_done_q;

    // Lookahead so DONE lands on the same edge as the last lane's final handshake
    always_comb begin
        all_done = 1'b1;
        for (int i = 0; i < NL; i++) begin
            if (!(lane_fin[i] || lane_last[i])) begin
                all_done = 1'b0;
            end
        end
    end

    // Buffer layout: lanes 0..M-1 hold rows of A, lanes M..M+K-1 hold columns of B,
    // which is exactly the load order, so the load counter is the write address.
    for (genvar l = 0; l < NL; l++) begin : g_lane
        single_float lbuf [N];

        always_comb begin
            for (int n = 0; n < N; n++) begin
                lbuf[n] = buf_q[l*N + n];
            end
        end

        if (l == 0 || l == M) begin : g_head
            assign lane_en[l] = feeding;
        end else begin : g_tail
            assign lane_en[l] = lane_start[l-1];
        end

        if (l < M) begin : g_row
            assign lane_rdy[l] = row_ready[l];
            assign row_valid[l] = lane_vld[l];
            assign row_dat[l*SNGL_FLT_SIZE +: SNGL_FLT_SIZE] = lane_dat[l];
        end else begin : g_col
            assign lane_rdy[l] = col_ready[l-M];
            assign col_valid[l-M] = lane_vld[l];
            assign col_dat[(l-M)*SNGL_FLT_SIZE +: SNGL_FLT_SIZE] = lane_dat[l];
        end

        operand_lane #(
            .N(N)
        ) u_lane (
            .clk      (clk),
            .nrst     (nrst),
            .clr      (clr),
            .en_in    (lane_en[l]),
            .buf_in   (lbuf),
            .ready    (lane_rdy[l]),
            .valid    (lane_vld[l]),
            .dat      (lane_dat[l]),
            .started  (lane_start[l]),
            .finished (lane_fin[l]),
            .last_hs  (lane_last[l])
        );
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q     <= IDLE;
            ld_cnt_q    <= '0;
            ld_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
            feed_done_q <= 1'b0;
            for (int i = 0; i < TOT; i++) begin
                buf_q[i] <= '0;
            end
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_q     <= LOAD;
                        ld_cnt_q    <= '0;
                        ld_ready_q  <= 1'b1;
                        busy_q      <= 1'b1;
                        feed_done_q <= 1'b0;
                    end
                end
                LOAD: begin
                    if (ld_hs) begin
                        buf_q[ld_cnt_q] <= ld_dat;
                        ld_cnt_q        <= ld_cnt_q + 1'b1;
                        if (ld_cnt_q == LW'(TOT - 1)) begin
                            state_q    <= FEED;
                            ld_ready_q <= 1'b0;
                        end
                    end
                end
                FEED: begin
                    if (all_done) begin
                        state_q     <= DONE;
                        busy_q      <= 1'b0;
                        feed_done_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sys_arr_operand_feeder.sv
// Directed bench for the operand feeder: load/feed sequences, skew, stalls, start/reset interference.
module tb_sys_arr_operand_feeder;
    import dsp_sys_arr_pkg::*;

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic        start = 1'b0;
    logic        ld_valid = 1'b0;
    logic        ld_ready;
    single_float ld_dat = '0;
    logic [63:0] row_dat, col_dat;
    logic [1:0]  row_valid, col_valid;
    logic [1:0]  row_ready = 2'b00;
    logic [1:0]  col_ready = 2'b00;
    logic        busy, feed_done;

    int nvec = 0;
    int nmis = 0;
    int cyc = 0;
    logic [31:0] lane_q [4][$];
    int first_v [4];
    int last_hs = -1;
    int fd_cyc = -1;
    bit ld_hs = 1'b0;

    logic [31:0] va [12] = '{1, 2, 3, 4, 5, 6, 1, 2, 3, 4, 5, 6};
    logic [31:0] vb [12] = '{10, 11, 12, 13, 14, 15, 20, 21, 22, 23, 24, 25};

    always #5 clk = ~clk;

    sys_arr_operand_feeder #(.M(2), .N(3), .K(2)) dut (
        .clk       (clk),
        .nrst      (nrst),
        .start     (start),
        .ld_valid  (ld_valid),
        .ld_ready  (ld_ready),
        .ld_dat    (ld_dat),
        .row_dat   (row_dat),
        .row_valid (row_valid),
        .row_ready (row_ready),
        .col_dat   (col_dat),
        .col_valid (col_valid),
        .col_ready (col_ready),
        .busy      (busy),
        .feed_done (feed_done)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nmis++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic lv(input int l);
        return (l < 2) ? row_valid[l] : col_valid[l-2];
    endfunction

    function automatic logic lr(input int l);
        return (l < 2) ? row_ready[l] : col_ready[l-2];
    endfunction

    function automatic logic [31:0] ldat(input int l);
        return (l < 2) ? row_dat[l*32 +: 32] : col_dat[(l-2)*32 +: 32];
    endfunction

    task automatic mon_clr();
        for (int l = 0; l < 4; l++) begin
            lane_q[l].delete();
            first_v[l] = -1;
        end
        last_hs = -1;
        fd_cyc  = -1;
    endtask

    // Sample handshakes mid-cycle, then advance past the next rising edge
    task automatic step();
        @(negedge clk);
        ld_hs = ld_valid && ld_ready;
        for (int l = 0; l < 4; l++) begin
            if (lv(l)) begin
                if (first_v[l] < 0) first_v[l] = cyc;
                if (lr(l)) begin
                    lane_q[l].push_back(ldat(l));
                    last_hs = cyc;
                end
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        if (feed_done && fd_cyc < 0) fd_cyc = cyc;
    endtask

    task automatic do_load(input logic [31:0] v [12], input bit thr, input bit poke);
        int n = 0;
        int g = 0;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("load_ld_ready", ld_ready, 1);
        chk("load_busy", busy, 1);
        while (n < 12 && g < 100) begin
            ld_valid = thr ? ~ld_valid : 1'b1;
            ld_dat   = v[n];
            start    = poke && (n == 5);
            step();
            g++;
            if (ld_hs) begin
                n++;
                if (thr && n == 11) begin
                    chk("pre12_ld_ready", ld_ready, 1);
                    chk("pre12_row_valid", row_valid[0], 0);
                end
            end
        end
        ld_valid = 1'b0;
        start    = 1'b0;
        chk("load_count", n, 12);
        chk("feed_ld_ready", ld_ready, 0);
        chk("feed_row0_valid", row_valid[0], 1);
        chk("feed_busy", busy, 1);
    endtask

    task automatic do_feed(input bit stall, input bit poke, input bit rst2);
        int g = 0;
        int sc = 0;
        int r1 = 0;
        logic [31:0] hold = '0;
        mon_clr();
        row_ready = 2'b11;
        col_ready = 2'b11;
        while (!feed_done && g < 60) begin
            start = poke && (g == 0);
            if (stall && lane_q[0].size() == 1 && sc < 3) begin
                if (sc == 0) begin
                    hold = row_dat[31:0];
                    r1   = lane_q[1].size();
                end
                row_ready[0] = 1'b0;
                step();
                sc++;
                chk("stall_row0_dat", row_dat[31:0], hold);
                chk("stall_row0_valid", row_valid[0], 1);
                if (sc == 3) chk("stall_row1_progress", lane_q[1].size() - r1, 3);
            end else begin
                row_ready[0] = 1'b1;
                if (rst2 && lane_q[0].size() == 2) begin
                    nrst = 1'b0;
                    #1;
                    chk("rst_row_valid", row_valid, 0);
                    chk("rst_col_valid", col_valid, 0);
                    chk("rst_feed_done", feed_done, 0);
                    chk("rst_busy", busy, 0);
                    chk("rst_ld_ready", ld_ready, 0);
                    chk("rst_row_dat", row_dat[31:0], 0);
                    @(posedge clk);
                    #1;
                    nrst = 1'b1;
                    start = 1'b0;
                    return;
                end
                step();
            end
            g++;
        end
        start = 1'b0;
        chk("feed_done", feed_done, 1);
        chk("done_valids", {row_valid, col_valid}, 0);
        chk("done_busy", busy, 0);
    endtask

    task automatic chk_seq(input logic [31:0] v [12]);
        for (int l = 0; l < 4; l++) begin
            chk($sformatf("lane%0d_len", l), lane_q[l].size(), 3);
            for (int n = 0; n < 3; n++) begin
                chk($sformatf("lane%0d_el%0d", l, n),
                    (n < lane_q[l].size()) ? lane_q[l][n] : 32'hDEAD_BEEF, v[l*3 + n]);
            end
        end
    endtask

    initial begin
        int acc;
        logic [31:0] exp_dot [2][2] = '{'{14, 32}, '{32, 77}};
        mon_clr();

        step();
        chk("rst_ld_ready0", ld_ready, 0);
        chk("rst_valids0", {row_valid, col_valid}, 0);
        chk("rst_busy0", busy, 0);
        chk("rst_done0", feed_done, 0);
        chk("rst_dat0", {row_dat, col_dat}, 0);
        nrst = 1'b1;
        row_ready = 2'b11;
        col_ready = 2'b11;
        step();
        chk("idle_valids", {row_valid, col_valid}, 0);

        // Basic load and feed
        do_load(va, 1'b0, 1'b0);
        do_feed(1'b0, 1'b0, 1'b0);
        chk_seq(va);
        chk("row1_skew", first_v[1] - first_v[0], 1);
        chk("col1_skew", first_v[3] - first_v[2], 1);
        chk("done_latency", fd_cyc - last_hs, 1);
        chk("done_hold_row0", row_dat[31:0], 3);
        chk("done_hold_col1", col_dat[63:32], 6);
        for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < 2; c++) begin
                acc = 0;
                for (int n = 0; n < 3 && n < lane_q[r].size() && n < lane_q[2+c].size(); n++)
                    acc += int'(lane_q[r][n]) * int'(lane_q[2+c][n]);
                chk($sformatf("dot_r%0dc%0d", r + 1, c + 1), acc, exp_dot[r][c]);
            end
        end

        // Throttled load from DONE, then a mid-stream stall on row lane 0
        do_load(va, 1'b1, 1'b0);
        do_feed(1'b1, 1'b0, 1'b0);
        chk_seq(va);

        // start pulses during LOAD and FEED are ignored; new operands replace old
        do_load(vb, 1'b0, 1'b1);
        do_feed(1'b0, 1'b1, 1'b0);
        chk_seq(vb);

        // Reset mid-feed, then a fresh load from IDLE
        do_load(va, 1'b0, 1'b0);
        do_feed(1'b0, 1'b0, 1'b1);
        step();
        chk("post_rst_valids", {row_valid, col_valid}, 0);
        do_load(vb, 1'b0, 1'b0);
        do_feed(1'b0, 1'b0, 1'b0);
        chk_seq(vb);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
